// File: rtl/arm_mem_pkg.sv
// Shared encodings for the multi-port ARM memory model: access sizes,
// exception codes, region ids and the per-port FSM states.
package arm_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_UNMAPPED = 2'd1;
  localparam logic [1:0] EXC_MISALIGN = 2'd2;
  localparam logic [1:0] EXC_WPROT    = 2'd3;

  typedef enum logic {
    REG_DATA = 1'b0,
    REG_TEXT = 1'b1
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // Number of bytes touched by an access; the reserved size counts as one
  // byte so its range check only looks at the first byte.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/arm_mem_port_fsm.sv
// One access port: request/ack handshake, wait-state counter, address
// decode and exception classification. The access strobe and its
// attributes are presented combinationally on the cycle whose rising edge
// enters ACK, so the top can read/commit memory on that very edge.
// Optional: ARM_MEM_TEXT_WRITE_PROTECT_EN turns TEXT writes into code 3.
module arm_mem_port_fsm
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] DATA_START  = 32'h1000_0000,
  parameter int          DATA_SIZE   = 256,
  parameter logic [31:0] TEXT_START  = 32'h0000_0000,
  parameter int          TEXT_SIZE   = 256,
  parameter int          WAIT_STATES = 0,
  parameter int          OFF_W       = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [1:0]       size_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  output logic             go_o,
  output logic             acc_o,
  output logic             we_o,
  output logic [1:0]       size_o,
  output region_e          region_o,
  output logic [OFF_W-1:0] off_o,
  output logic [31:0]      wdata_o,
  output logic             ack_o,
  output logic [1:0]       excpt_o
);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             we_q;
  logic [1:0]       size_q;
  region_e          region_q;
  logic [OFF_W-1:0] off_q;
  logic [31:0]      wdata_q;
  logic [1:0]       exc_q;
  logic             ack_q;
  logic [1:0]       excpt_q;

  logic [31:0]      d_off_s;
  logic [31:0]      t_off_s;
  logic [32:0]      nb_s;
  logic             fit_d_s;
  logic             fit_t_s;
  logic             mis_s;
  region_e          dec_region_s;
  logic [OFF_W-1:0] dec_off_s;
  logic [1:0]       dec_exc_s;
  logic [1:0]       cur_exc_s;
  logic             go_s;

  // Decode the incoming request: region hit (DATA first), offset, exception.
  always_comb begin
    d_off_s = addr_i - DATA_START;
    t_off_s = addr_i - TEXT_START;
    nb_s    = {30'd0, size_bytes(size_i)};
    // A wrapped offset (address below base) is huge, so one compare covers both ends.
    fit_d_s = (({1'b0, d_off_s} + nb_s) <= 33'(DATA_SIZE));
    fit_t_s = (({1'b0, t_off_s} + nb_s) <= 33'(TEXT_SIZE));
    case (size_i)
      SZ_BYTE: mis_s = 1'b0;
      SZ_HALF: mis_s = addr_i[0];
      SZ_WORD: mis_s = (addr_i[1:0] != 2'd0);
      default: mis_s = 1'b1;
    endcase
    dec_region_s = REG_DATA;
    dec_off_s    = d_off_s[OFF_W-1:0];
    dec_exc_s    = EXC_NONE;
    if (fit_d_s) begin
      dec_region_s = REG_DATA;
      dec_off_s    = d_off_s[OFF_W-1:0];
    end else if (fit_t_s) begin
      dec_region_s = REG_TEXT;
      dec_off_s    = t_off_s[OFF_W-1:0];
    end else begin
      dec_exc_s    = EXC_UNMAPPED;
    end
    if (dec_exc_s == EXC_NONE && mis_s) begin
      dec_exc_s = EXC_MISALIGN;
    end else begin
      dec_exc_s = dec_exc_s;
    end
`ifdef ARM_MEM_TEXT_WRITE_PROTECT_EN
    if (dec_exc_s == EXC_NONE && we_i && dec_region_s == REG_TEXT) begin
      dec_exc_s = EXC_WPROT;
    end else begin
      dec_exc_s = dec_exc_s;
    end
`endif
  end

  // Present the access attributes: live decode in IDLE, latched ones in WAIT/ACK.
  always_comb begin
    if (state_q == ST_IDLE) begin
      we_o      = we_i;
      size_o    = size_i;
      region_o  = dec_region_s;
      off_o     = dec_off_s;
      wdata_o   = wdata_i;
      cur_exc_s = dec_exc_s;
    end else begin
      we_o      = we_q;
      size_o    = size_q;
      region_o  = region_q;
      off_o     = off_q;
      wdata_o   = wdata_q;
      cur_exc_s = exc_q;
    end
    if (reset_i) begin
      go_s = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: go_s = req_i && (WAIT_STATES == 0);
        ST_WAIT: go_s = (cnt_q == 4'd1);
        default: go_s = 1'b0;
      endcase
    end
    go_o  = go_s;
    acc_o = go_s && (cur_exc_s == EXC_NONE);
  end

  // Handshake FSM with wait counter and registered ack/exception outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      region_q <= REG_DATA;
      off_q    <= '0;
      wdata_q  <= 32'd0;
      exc_q    <= EXC_NONE;
      ack_q    <= 1'b0;
      excpt_q  <= EXC_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          if (req_i) begin
            we_q     <= we_i;
            size_q   <= size_i;
            region_q <= dec_region_s;
            off_q    <= dec_off_s;
            wdata_q  <= wdata_i;
            exc_q    <= dec_exc_s;
            cnt_q    <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
              excpt_q <= dec_exc_s;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            excpt_q <= exc_q;
          end
        end
        ST_ACK: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_o   = ack_q;
  assign excpt_o = excpt_q;

endmodule

// File: rtl/arm_memory_mp.sv
// Multi-port big-endian ARM memory model with DATA and TEXT regions.
// Owns both byte arrays, the per-port read mux and the write commit loop;
// ports are walked in ascending order so the highest index wins a byte.
// Optional: ARM_MEM_TEXT_WRITE_PROTECT_EN (handled in arm_mem_port_fsm).
module arm_memory_mp
  import arm_mem_pkg::*;
#(
  parameter int          NB_PORTS    = 2,
  parameter logic [31:0] DATA_START  = 32'h1000_0000,
  parameter int          DATA_SIZE   = 256,
  parameter logic [31:0] TEXT_START  = 32'h0000_0000,
  parameter int          TEXT_SIZE   = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NB_PORTS-1:0]    req,
  input  logic [NB_PORTS-1:0]    we,
  input  logic [2*NB_PORTS-1:0]  size,
  input  logic [32*NB_PORTS-1:0] addr,
  input  logic [32*NB_PORTS-1:0] wdata,
  output logic [NB_PORTS-1:0]    ack,
  output logic [32*NB_PORTS-1:0] rdata,
  output logic [2*NB_PORTS-1:0]  excpt
);

  localparam int MAX_SIZE = (DATA_SIZE > TEXT_SIZE) ? DATA_SIZE : TEXT_SIZE;
  localparam int OFF_W    = $clog2(MAX_SIZE);

  logic [7:0] data_mem [DATA_SIZE];
  logic [7:0] text_mem [TEXT_SIZE];

  logic             go_s     [NB_PORTS];
  logic             acc_s    [NB_PORTS];
  logic             we_s     [NB_PORTS];
  logic [1:0]       size_s   [NB_PORTS];
  region_e          region_s [NB_PORTS];
  logic [OFF_W-1:0] off_s    [NB_PORTS];
  logic [31:0]      wdata_s  [NB_PORTS];
  logic [31:0]      wal_s    [NB_PORTS];
  logic [31:0]      rd_s     [NB_PORTS];
  logic [31:0]      rdata_q  [NB_PORTS];

  for (genvar p = 0; p < NB_PORTS; p++) begin : g_port
    arm_mem_port_fsm #(
      .DATA_START  (DATA_START),
      .DATA_SIZE   (DATA_SIZE),
      .TEXT_START  (TEXT_START),
      .TEXT_SIZE   (TEXT_SIZE),
      .WAIT_STATES (WAIT_STATES),
      .OFF_W       (OFF_W)
    ) u_fsm (
      .clk_i    (clk),
      .reset_i  (reset),
      .req_i    (req[p]),
      .we_i     (we[p]),
      .size_i   (size[2*p +: 2]),
      .addr_i   (addr[32*p +: 32]),
      .wdata_i  (wdata[32*p +: 32]),
      .go_o     (go_s[p]),
      .acc_o    (acc_s[p]),
      .we_o     (we_s[p]),
      .size_o   (size_s[p]),
      .region_o (region_s[p]),
      .off_o    (off_s[p]),
      .wdata_o  (wdata_s[p]),
      .ack_o    (ack[p]),
      .excpt_o  (excpt[2*p +: 2])
    );

    // Big-endian read mux: gather the addressed bytes, zero-extended, right-aligned.
    always_comb begin
      rd_s[p] = 32'd0;
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < size_bytes(size_s[p])) begin
          if (region_s[p] == REG_DATA) begin
            rd_s[p] = {rd_s[p][23:0], data_mem[off_s[p] + OFF_W'(k)]};
          end else begin
            rd_s[p] = {rd_s[p][23:0], text_mem[off_s[p] + OFF_W'(k)]};
          end
        end else begin
          rd_s[p] = rd_s[p];
        end
      end
    end

    // Left-align write data so byte k of the access is always wal[31-8k -: 8].
    always_comb begin
      wal_s[p] = wdata_s[p] << {(3'd4 - size_bytes(size_s[p])), 3'b000};
    end

    // Register read data on the access edge; exceptions and writes return zero.
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_q[p] <= 32'd0;
      end else if (go_s[p]) begin
        rdata_q[p] <= (acc_s[p] && !we_s[p]) ? rd_s[p] : 32'd0;
      end
    end

    assign rdata[32*p +: 32] = rdata_q[p];
  end

  // Commit writes in ascending port order; the last assignment to a byte wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NB_PORTS; p++) begin
        if (acc_s[p] && we_s[p]) begin
          for (int k = 0; k < 4; k++) begin
            if (3'(k) < size_bytes(size_s[p])) begin
              if (region_s[p] == REG_DATA) begin
                data_mem[off_s[p] + OFF_W'(k)] <= wal_s[p][8*(3-k) +: 8];
              end else begin
                text_mem[off_s[p] + OFF_W'(k)] <= wal_s[p][8*(3-k) +: 8];
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_arm_memory_mp.sv
// Directed bench for arm_memory_mp: dut0 uses zero wait states, dut3 uses
// three. Expected values are hand-computed from the big-endian byte layout.
module tb_arm_memory_mp;

  logic        clk;
  logic        rst_v   [2];
  logic [1:0]  req_v   [2];
  logic [1:0]  we_v    [2];
  logic [3:0]  size_v  [2];
  logic [63:0] addr_v  [2];
  logic [63:0] wdata_v [2];
  logic [1:0]  ack_v   [2];
  logic [63:0] rdata_v [2];
  logic [3:0]  excpt_v [2];

  int n_chk;
  int n_pass;

  arm_memory_mp #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst_v[0]), .req(req_v[0]), .we(we_v[0]), .size(size_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .ack(ack_v[0]), .rdata(rdata_v[0]),
    .excpt(excpt_v[0])
  );

  arm_memory_mp #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(rst_v[1]), .req(req_v[1]), .we(we_v[1]), .size(size_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .ack(ack_v[1]), .rdata(rdata_v[1]),
    .excpt(excpt_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port access on DUT d; lat = posedges from request until ack, -1 on timeout.
  task automatic access(input int d, input int p, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic [1:0] ex, output int lat);
    @(negedge clk);
    we_v[d][p]            = w;
    size_v[d][2*p +: 2]   = sz;
    addr_v[d][32*p +: 32] = a;
    wdata_v[d][32*p +: 32] = wd;
    req_v[d][p]           = 1'b1;
    lat = -1;
    rd  = 32'd0;
    ex  = 2'd0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (ack_v[d][p]) begin
        lat = i;
        rd  = rdata_v[d][32*p +: 32];
        ex  = excpt_v[d][2*p +: 2];
        break;
      end
    end
    req_v[d][p] = 1'b0;
    @(posedge clk);
  endtask

  // Both ports of dut0 issue on the same edge; returns port0 read data.
  task automatic access2(input logic w0, input logic [31:0] wd0,
                         input logic w1, input logic [31:0] wd1,
                         input logic [31:0] a, output logic [31:0] rd0, output int lat);
    @(negedge clk);
    we_v[0]    = {w1, w0};
    size_v[0]  = {2'd2, 2'd2};
    addr_v[0]  = {a, a};
    wdata_v[0] = {wd1, wd0};
    req_v[0]   = 2'b11;
    lat = -1;
    rd0 = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (ack_v[0] == 2'b11) begin
        lat = i;
        rd0 = rdata_v[0][31:0];
        break;
      end
    end
    req_v[0] = 2'b00;
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_v[0] = 1'b1;
    rst_v[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (ack_v[0] !== 2'b00) $display("FAIL reset_ack: got %b want 00", ack_v[0]); else n_pass++;
    n_chk++; if (rdata_v[0] !== 64'd0) $display("FAIL reset_rdata: got %h want 0", rdata_v[0]); else n_pass++;
    n_chk++; if (excpt_v[0] !== 4'd0) $display("FAIL reset_excpt: got %h want 0", excpt_v[0]); else n_pass++;
    @(negedge clk);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic [1:0] ex; int lat;
    access(0, 0, 1'b1, 2'd2, 32'h1000_0000, 32'hDEAD_BEEF, rd, ex, lat);
    n_chk++; if (lat !== 1) $display("FAIL word_wr_lat: got %0d want 1", lat); else n_pass++;
    n_chk++; if (ex !== 2'd0) $display("FAIL word_wr_exc: got %0d want 0", ex); else n_pass++;
    access(0, 0, 1'b0, 2'd2, 32'h1000_0000, 32'd0, rd, ex, lat);
    n_chk++; if (lat !== 1) $display("FAIL word_rd_lat: got %0d want 1", lat); else n_pass++;
    n_chk++; if (rd !== 32'hDEAD_BEEF) $display("FAIL word_rd: got %h want deadbeef", rd); else n_pass++;
    n_chk++; if (ex !== 2'd0) $display("FAIL word_rd_exc: got %0d want 0", ex); else n_pass++;
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic [1:0] ex; int lat;
    access(0, 0, 1'b0, 2'd0, 32'h1000_0001, 32'd0, rd, ex, lat);
    n_chk++; if (rd !== 32'h0000_00AD) $display("FAIL byte_rd: got %h want 000000ad", rd); else n_pass++;
    access(0, 1, 1'b0, 2'd1, 32'h1000_0000, 32'd0, rd, ex, lat);
    n_chk++; if (rd !== 32'h0000_DEAD) $display("FAIL half_rd_p1: got %h want 0000dead", rd); else n_pass++;
    access(0, 0, 1'b1, 2'd1, 32'h1000_0002, 32'h0000_1234, rd, ex, lat);
    access(0, 0, 1'b0, 2'd2, 32'h1000_0000, 32'd0, rd, ex, lat);
    n_chk++; if (rd !== 32'hDEAD_1234) $display("FAIL half_wr_readback: got %h want dead1234", rd); else n_pass++;
  endtask

  task automatic test_exceptions();
    logic [31:0] rd; logic [1:0] ex; int lat;
    access(0, 0, 1'b0, 2'd2, 32'h1000_0102, 32'd0, rd, ex, lat);
    n_chk++; if (ex !== 2'd1) $display("FAIL exc_beyond_top: got %0d want 1", ex); else n_pass++;
    n_chk++; if (rd !== 32'd0) $display("FAIL exc_beyond_top_rd: got %h want 0", rd); else n_pass++;
    access(0, 0, 1'b0, 2'd1, 32'h1000_0003, 32'd0, rd, ex, lat);
    n_chk++; if (ex !== 2'd2) $display("FAIL exc_half_mis: got %0d want 2", ex); else n_pass++;
    n_chk++; if (rd !== 32'd0) $display("FAIL exc_half_mis_rd: got %h want 0", rd); else n_pass++;
    access(0, 0, 1'b0, 2'd2, 32'h1000_00FE, 32'd0, rd, ex, lat);
    n_chk++; if (ex !== 2'd1) $display("FAIL exc_straddle: got %0d want 1", ex); else n_pass++;
    n_chk++; if (rd !== 32'd0) $display("FAIL exc_straddle_rd: got %h want 0", rd); else n_pass++;
    access(0, 0, 1'b0, 2'd3, 32'h1000_0000, 32'd0, rd, ex, lat);
    n_chk++; if (ex !== 2'd2) $display("FAIL exc_size3: got %0d want 2", ex); else n_pass++;
    access(0, 0, 1'b0, 2'd2, 32'h1000_0101, 32'd0, rd, ex, lat);
    n_chk++; if (ex !== 2'd1) $display("FAIL exc_unmapped_prio: got %0d want 1", ex); else n_pass++;
    access(0, 0, 1'b0, 2'd2, 32'h1000_00FC, 32'd0, rd, ex, lat);
    n_chk++; if (ex !== 2'd0) $display("FAIL data_top_word: got %0d want 0", ex); else n_pass++;
    access(0, 0, 1'b1, 2'd1, 32'h1000_0003, 32'h0000_FFFF, rd, ex, lat);
    n_chk++; if (ex !== 2'd2) $display("FAIL exc_mis_wr: got %0d want 2", ex); else n_pass++;
    access(0, 0, 1'b0, 2'd2, 32'h1000_0000, 32'd0, rd, ex, lat);
    n_chk++; if (rd !== 32'hDEAD_1234) $display("FAIL exc_mem_unchanged: got %h want dead1234", rd); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd; logic [1:0] ex; int lat;
    access2(1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 32'h1000_0010, rd, lat);
    n_chk++; if (lat !== 1) $display("FAIL ww_lat: got %0d want 1", lat); else n_pass++;
    access(0, 0, 1'b0, 2'd2, 32'h1000_0010, 32'd0, rd, ex, lat);
    n_chk++; if (rd !== 32'h2222_2222) $display("FAIL ww_high_wins: got %h want 22222222", rd); else n_pass++;
    access2(1'b0, 32'd0, 1'b1, 32'h3333_3333, 32'h1000_0010, rd, lat);
    n_chk++; if (rd !== 32'h2222_2222) $display("FAIL rw_old_value: got %h want 22222222", rd); else n_pass++;
    access(0, 1, 1'b0, 2'd2, 32'h1000_0010, 32'd0, rd, ex, lat);
    n_chk++; if (rd !== 32'h3333_3333) $display("FAIL rw_new_value: got %h want 33333333", rd); else n_pass++;
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic [1:0] ex; int lat; int seen;
    access(1, 0, 1'b1, 2'd2, 32'h1000_0020, 32'hCAFE_F00D, rd, ex, lat);
    n_chk++; if (lat !== 4) $display("FAIL ws_wr_lat: got %0d want 4", lat); else n_pass++;
    access(1, 1, 1'b0, 2'd2, 32'h1000_0020, 32'd0, rd, ex, lat);
    n_chk++; if (lat !== 4) $display("FAIL ws_rd_lat: got %0d want 4", lat); else n_pass++;
    n_chk++; if (rd !== 32'hCAFE_F00D) $display("FAIL ws_rd: got %h want cafef00d", rd); else n_pass++;
    // Write pending in WAIT, reset lands on the edge that would commit it.
    @(negedge clk);
    we_v[1][0] = 1'b1;
    size_v[1][1:0] = 2'd2;
    addr_v[1][31:0] = 32'h1000_0020;
    wdata_v[1][31:0] = 32'h1234_5678;
    req_v[1][0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_v[1] = 1'b1;
    @(posedge clk);
    #1;
    seen = int'(ack_v[1][0]);
    @(negedge clk);
    rst_v[1] = 1'b0;
    req_v[1][0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ack_v[1][0]) seen = seen + 1;
    end
    n_chk++; if (seen !== 0) $display("FAIL ws_reset_no_ack: got %0d acks want 0", seen); else n_pass++;
    access(1, 0, 1'b0, 2'd2, 32'h1000_0020, 32'd0, rd, ex, lat);
    n_chk++; if (rd !== 32'hCAFE_F00D) $display("FAIL ws_reset_no_commit: got %h want cafef00d", rd); else n_pass++;
  endtask

  task automatic test_text();
    logic [31:0] rd; logic [1:0] ex; int lat;
    access(0, 0, 1'b1, 2'd2, 32'h0000_0040, 32'hAABB_CCDD, rd, ex, lat);
`ifdef ARM_MEM_TEXT_WRITE_PROTECT_EN
    n_chk++; if (ex !== 2'd3) $display("FAIL text_wprot: got %0d want 3", ex); else n_pass++;
    access(0, 0, 1'b0, 2'd2, 32'h0000_0040, 32'd0, rd, ex, lat);
    n_chk++; if (rd === 32'hAABB_CCDD) $display("FAIL text_unchanged: got %h want not aabbccdd", rd); else n_pass++;
`else
    n_chk++; if (ex !== 2'd0) $display("FAIL text_wr_exc: got %0d want 0", ex); else n_pass++;
    access(0, 0, 1'b0, 2'd2, 32'h0000_0040, 32'd0, rd, ex, lat);
    n_chk++; if (rd !== 32'hAABB_CCDD) $display("FAIL text_readback: got %h want aabbccdd", rd); else n_pass++;
    access(0, 1, 1'b0, 2'd0, 32'h0000_0041, 32'd0, rd, ex, lat);
    n_chk++; if (rd !== 32'h0000_00BB) $display("FAIL text_byte: got %h want 000000bb", rd); else n_pass++;
`endif
    access(0, 0, 1'b0, 2'd2, 32'h0000_0100, 32'd0, rd, ex, lat);
    n_chk++; if (ex !== 2'd1) $display("FAIL text_above_top: got %0d want 1", ex); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    for (int d = 0; d < 2; d++) begin
      rst_v[d]   = 1'b1;
      req_v[d]   = 2'b00;
      we_v[d]    = 2'b00;
      size_v[d]  = 4'd0;
      addr_v[d]  = 64'd0;
      wdata_v[d] = 64'd0;
    end
    test_reset();
    test_word();
    test_byte_half();
    test_exceptions();
    test_simultaneous();
    test_wait_states();
    test_text();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/arm_memory_mp.md
Name: arm_memory_mp

Overview:
- Parametrised successor to the dual-port, two-region ARM memory model.
- NB_PORTS independent request/ack ports share one big-endian byte store split into a DATA region and a TEXT region.
- Supports byte, halfword and word accesses, a configurable number of wait states, and coded exceptions (unmapped, misaligned).
- Sits between the CPU fetch/load-store stages and the simulation memory image.

Parameters:
- NB_PORTS, 2, number of independent access ports.
- DATA_START, 32'h10000000, base byte address of the DATA region.
- DATA_SIZE, 256, DATA region size in bytes (multiple of 4).
- TEXT_START, 32'h00000000, base byte address of the TEXT region.
- TEXT_SIZE, 256, TEXT region size in bytes (multiple of 4).
- WAIT_STATES, 0, extra cycles between acceptance and ack (0..15).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NB_PORTS  per-port request; held high until ack.
- we  in  NB_PORTS  per-port write enable, sampled on acceptance.
- size  in  2*NB_PORTS  per-port access size: 0 byte, 1 half, 2 word, 3 reserved (treated as misaligned).
- addr  in  32*NB_PORTS  per-port byte address.
- wdata  in  32*NB_PORTS  per-port write data, right-aligned (byte in [7:0], half in [15:0]).
- ack  out  NB_PORTS  one-cycle completion pulse per port.
- rdata  out  32*NB_PORTS  read data, zero-extended and right-aligned; valid when ack is high.
- excpt  out  2*NB_PORTS  exception code, valid when ack is high: 0 none, 1 unmapped, 2 misaligned, 3 write-protect.

Behaviour:
- Reset (synchronous, active-high):
  - Every port FSM goes to IDLE.
  - ack=0, rdata=0, excpt=0.
  - Memory contents are not reset.
  - A reset on the same edge as a write commit suppresses the commit.
- Per-port FSM states: IDLE, WAIT, ACK.
  - IDLE: when req=1, latch we/size/addr/wdata, decode, and load wait counter = WAIT_STATES. Go to WAIT if WAIT_STATES>0, otherwise to ACK.
  - WAIT: decrement the counter. Leave for ACK on the edge where the counter reaches 1.
  - ACK: ack=1 for exactly one cycle. req is ignored in this cycle. Next state is IDLE.
- Latency: ack is high WAIT_STATES+1 cycles after the acceptance edge. Throughput is one access per WAIT_STATES+2 cycles per port.
- Access edge: the memory access happens on the edge that enters ACK.
  - Read: rdata is registered on that edge.
  - Write: bytes commit on that edge.
- Dropping req in WAIT is a protocol violation. The FSM still completes and issues ack.
- Decode priority: DATA range [START, START+SIZE), then TEXT, otherwise unmapped.
  - An access whose last byte exceeds the region top is unmapped.
  - Unmapped wins over misaligned.
- Misaligned conditions: half with addr[0]=1; word with addr[1:0]!=0; size=3.
- On any exception: no memory change, rdata=0, ack still issued.
- Byte order is big-endian. For a word at offset o: byte o maps to rdata[31:24] and o+3 maps to rdata[7:0].
- Simultaneous events:
  - Write/write to the same byte on the same edge: the higher port index wins.
  - Read and write to the same byte on the same edge: the read returns the old value (read-before-write).
- Ports are fully independent; there is no arbitration stall.

Optional Feature:
- Macro: ARM_MEM_TEXT_WRITE_PROTECT_EN.
- Defined: any write decoding to TEXT acks with excpt=3 and leaves memory unchanged. Writes to text are then only possible through $readmemh preload.
- Undefined: TEXT is writable like DATA and code 3 is never produced.

Decomposition:
- Package arm_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - exception codes EXC_NONE/EXC_UNMAPPED/EXC_MISALIGN/EXC_WPROT;
  - region ids REG_DATA/REG_TEXT;
  - FSM state encodings.
- Sub-module arm_mem_port_fsm: one instance per port via generate. It owns the handshake, wait counter, decode and exception code, and outputs access-strobe, region, offset, size and we to the top.
- The top owns both byte arrays, the read mux and the write commit loop (ascending port order, giving the higher-index-wins rule).

Test Plan:
- Reset with WAIT_STATES=0: assert reset 2 cycles -> ack=0, rdata=0, excpt=0. Then port0 word write 32'hDEADBEEF at 32'h10000000, then word read -> ack 1 cycle after acceptance each time; rdata=32'hDEADBEEF, excpt=0.
- Byte and half accesses:
  - Byte read at 32'h10000001 after the above -> rdata=32'h000000AD.
  - Half write 16'h1234 at 32'h10000002, then word read -> 32'hDEAD1234.
- Exceptions: word read at 32'h10000102 -> excpt=1; half at 32'h10000003 -> excpt=2; word at 32'h100000FE -> excpt=1. In all cases rdata=0 and memory is unchanged.
- Simultaneous writes: port0 writes 32'h11111111 and port1 writes 32'h22222222 to 32'h10000010 on the same edge -> readback 32'h22222222. Port0 read with port1 write to the same address on the same edge -> old value returned.
- WAIT_STATES=3: ack exactly 4 cycles after acceptance. Reset asserted in WAIT on a pending write -> no ack, memory unchanged.
- ARM_MEM_TEXT_WRITE_PROTECT_EN defined: word write to 32'h00000040 -> excpt=3 and text unchanged. Undefined -> excpt=0 and readback matches.
